uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Writer side of the instruction-ROM UART programming interface; produces the upg_* write strobe, address, data and done signals consumed by the instruction-fetch ROM port.
- Deserialises 8N1 UART bytes into a 2-byte little-endian word-count header, then that many 32-bit little-endian words.
- Issues one ROM write per word at consecutive word addresses, then asserts a sticky done.
- Sits between the board RX pin and the fetch unit, in the same clock domain as the ROM write port.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 14, ROM word-address width; depth = 2**ADDR_W words.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- upg_rst_i  in  1  high holds the loader idle and clears progress; a session starts when it falls.
- rx_i  in  1  UART serial input, idle high, asynchronous to clock.
- upg_clk_o  out  1  equals clock; ROM write-port clock.
- upg_wen_o  out  1  one-cycle ROM write strobe.
- upg_adr_o  out  ADDR_W  ROM word address.
- upg_dat_o  out  32  ROM write data.
- upg_done_o  out  1  sticky: programming complete.
- err_o  out  1  sticky: framing error or count overflow seen this session.

Behaviour:
- Reset (reset=0): all outputs 0 except upg_clk_o; FSM in HDR0; byte counter, word counter and count register cleared.
- upg_rst_i=1 on any clock edge: synchronous return to HDR0 with the same clear as reset, including upg_done_o and err_o. Bytes received while it is high are discarded.
- Byte receiver:
  - rx_i passes through a 2-FF synchroniser.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if high, the frame is a glitch and is dropped silently.
  - Data bits are sampled LSB-first every CLKS_PER_BIT, measured from the mid-start sample.
  - Stop bit: if 1, rx_valid pulses one cycle with the byte. If 0, the byte is dropped, err_o is set, and the FSM does not advance.
  - The receiver returns to idle after the stop-bit sample.
- FSM states and transitions:
  - HDR0: on rx_valid, cnt[7:0] = byte; go to HDR1.
  - HDR1: on rx_valid, cnt[15:8] = byte. Then:
    - N = {cnt[15:8], cnt[7:0]}.
    - N == 0 → DONE.
    - N > 2**ADDR_W → N is saturated to 2**ADDR_W, err_o is set, go to DATA.
    - Otherwise → DATA.
  - DATA: bytes 0..3 of each word fill dat[7:0], dat[15:8], dat[23:16], dat[31:24].
  - On the 4th byte, the next cycle has upg_wen_o=1 for exactly one cycle, upg_adr_o = word index, upg_dat_o = assembled word.
  - In the cycle after the strobe, the word index increments. If index+1 == N, go to DONE.
  - DONE: upg_done_o=1 and held; upg_wen_o=0; further bytes are ignored until upg_rst_i or reset.
- Outputs: upg_adr_o and upg_dat_o hold their last-written values between strobes and in DONE.
- Write-strobe spacing: strobes are at least 4*10*CLKS_PER_BIT cycles apart, so no back-pressure is needed.
- Word index is ADDR_W+1 bits wide, so the compare with N = 2**ADDR_W terminates correctly. The last address written is 2**ADDR_W-1; the address never wraps.
- If a byte's stop sample and upg_rst_i=1 occur on the same edge, the clear wins and the byte is lost.
- Asserting reset mid-frame or mid-word aborts at once. A partial word is never written.

Decomposition:
- Shared package holds:
  - FSM state encoding (HDR0, HDR1, DATA, DONE; 2 bits).
  - UART constants: data bits = 8, stop bits = 1, idle level = 1.
- One sub-module, uart_rx_byte (parameter CLKS_PER_BIT):
  - Inputs: clock, reset, clr, rx_i.
  - Outputs: rx_valid, rx_byte, frame_err.
  - Contains the synchroniser, bit timer and shift register.
- Top level holds the header/word assembly FSM and counters.

Test Plan (CLKS_PER_BIT=16, ADDR_W=4):
- Send 0x02 0x00, then 0x78 0x56 0x34 0x12, then 0xEF 0xBE 0xAD 0xDE → two strobes: adr 0 dat 0x12345678, then adr 1 dat 0xDEADBEEF; then upg_done_o=1 and err_o=0.
- Send header 0x00 0x00 → upg_done_o=1 within 2 cycles of the 2nd rx_valid; no upg_wen_o pulse.
- Send header 0x20 0x00 (32 > 16), then 64 bytes → err_o=1 after the header; exactly 16 strobes at adr 0..15; done after adr 15; bytes 65+ produce no writes.
- Mid-word, send one byte with stop bit 0, then valid bytes → err_o=1; the bad byte is not counted; the word assembles from the next 4 good bytes.
- Pull rx_i low for 4 cycles only → no rx_valid, err_o stays 0.
- After 2 of 4 bytes of word 0, assert reset=0 for 3 cycles, then resend the full stream → no write before the resend; strobes match the first test. Repeat with upg_rst_i=1 pulsed after done → done clears and a new session programs from adr 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and UART framing constants for the instruction-ROM UART loader.
// Both FSM encodings live here so checkers and the bench can decode debug state.
package uart_prog_loader_pkg;

   typedef enum logic [1:0] {
      ST_HDR0 = 2'd0,
      ST_HDR1 = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } load_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam int   UART_STOP_BITS = 1;
   localparam logic UART_IDLE_LVL  = 1'b1;

   // Width of the little-endian word-count header.
   localparam int   HDR_W          = 16;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling timer, LSB-first shifter.
// rx_valid_o is a one-cycle pulse with rx_byte_o valid in that cycle; there is no ready.
module uart_rx_byte
   import uart_prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clr_i,
   input  logic                      rx_i,
   output logic                      rx_valid_o,
   output logic [UART_DATA_BITS-1:0] rx_byte_o,
   output logic                      frame_err_o,
   output rx_state_t                 state_o
);

   localparam int                   CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam int                   IDX_W     = $clog2(UART_DATA_BITS);
   localparam logic [IDX_W-1:0]     DATA_LAST = IDX_W'(UART_DATA_BITS - 1);
   localparam logic [IDX_W-1:0]     STOP_LAST = IDX_W'(UART_STOP_BITS - 1);

   logic                      rx_meta_q;
   logic                      rx_sync_q;
   logic                      rx_prev_q;
   rx_state_t                 state_q;
   logic [CNT_W-1:0]          tmr_q;
   logic [CNT_W-1:0]          tmr_d;
   logic [IDX_W-1:0]          bit_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] byte_q;
   logic                      valid_q;
   logic                      ferr_q;
   logic                      start_edge_d;

   assign tmr_d        = tmr_q + 1'b1;
   assign start_edge_d = (rx_prev_q == UART_IDLE_LVL) && (rx_sync_q != UART_IDLE_LVL);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= UART_IDLE_LVL;
         rx_sync_q <= UART_IDLE_LVL;
         rx_prev_q <= UART_IDLE_LVL;
         state_q   <= RX_IDLE;
         tmr_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         tmr_q     <= tmr_d;
         if (clr_i) begin
            state_q <= RX_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
         end else begin
            case (state_q)
               RX_IDLE: begin
                  tmr_q <= '0;
                  bit_q <= '0;
                  if (start_edge_d) state_q <= RX_START;
               end
               RX_START: begin
                  // Line back high at mid-start means a glitch, not a frame.
                  if (tmr_q == HALF_LAST) begin
                     tmr_q   <= '0;
                     state_q <= (rx_sync_q == UART_IDLE_LVL) ? RX_IDLE : RX_DATA;
                  end
               end
               RX_DATA: begin
                  if (tmr_q == BIT_LAST) begin
                     tmr_q   <= '0;
                     shift_q <= {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == DATA_LAST) begin
                        bit_q   <= '0;
                        state_q <= RX_STOP;
                     end
                  end
               end
               RX_STOP: begin
                  if (tmr_q == BIT_LAST) begin
                     tmr_q <= '0;
                     if (rx_sync_q != UART_IDLE_LVL) begin
                        ferr_q  <= 1'b1;
                        state_q <= RX_IDLE;
                     end else if (bit_q == STOP_LAST) begin
                        valid_q <= 1'b1;
                        byte_q  <= shift_q;
                        state_q <= RX_IDLE;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end
               end
               default: state_q <= RX_IDLE;
            endcase
         end
      end
   end

   assign rx_valid_o  = valid_q;
   assign rx_byte_o   = byte_q;
   assign frame_err_o = ferr_q;
   assign state_o     = state_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART instruction-ROM programmer: 16-bit LE word count, then that many 32-bit LE words,
// one upg_wen_o strobe per word at consecutive addresses, then a sticky upg_done_o.
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              upg_rst_i,
   input  logic              rx_i,
   output logic              upg_clk_o,
   output logic              upg_wen_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [31:0]       upg_dat_o,
   output logic              upg_done_o,
   output logic              err_o,
   output load_state_t       dbg_state_o,
   output rx_state_t         dbg_rx_state_o
);

   // ADDR_W must stay below HDR_W so the full ROM depth is representable as a count.
   localparam logic [HDR_W-1:0] ROM_DEPTH = HDR_W'(2 ** ADDR_W);

   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              rx_ferr;

   load_state_t       state_q;
   logic [HDR_W-1:0]  cnt_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       dat_q;
   logic [ADDR_W:0]   widx_q;
   logic              wen_q;
   logic [ADDR_W-1:0] adr_q;
   logic [31:0]       wdat_q;
   logic              done_q;
   logic              err_q;

   logic [HDR_W-1:0]  hdr_n_d;
   logic [ADDR_W:0]   widx_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clock       (clock),
      .reset       (reset),
      .clr_i       (upg_rst_i),
      .rx_i        (rx_i),
      .rx_valid_o  (rx_valid),
      .rx_byte_o   (rx_byte),
      .frame_err_o (rx_ferr),
      .state_o     (dbg_rx_state_o)
   );

   assign hdr_n_d = {rx_byte, cnt_q[7:0]};
   assign widx_d  = widx_q + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_HDR0;
         cnt_q      <= '0;
         byte_idx_q <= '0;
         dat_q      <= '0;
         widx_q     <= '0;
         wen_q      <= 1'b0;
         adr_q      <= '0;
         wdat_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else if (upg_rst_i) begin
         state_q    <= ST_HDR0;
         cnt_q      <= '0;
         byte_idx_q <= '0;
         dat_q      <= '0;
         widx_q     <= '0;
         wen_q      <= 1'b0;
         adr_q      <= '0;
         wdat_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wen_q <= 1'b0;
         if (rx_ferr) err_q <= 1'b1;
         case (state_q)
            ST_HDR0: begin
               if (rx_valid) begin
                  cnt_q[7:0] <= rx_byte;
                  state_q    <= ST_HDR1;
               end
            end
            ST_HDR1: begin
               if (rx_valid) begin
                  byte_idx_q <= '0;
                  if (hdr_n_d == '0) begin
                     cnt_q   <= hdr_n_d;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (hdr_n_d > ROM_DEPTH) begin
                     cnt_q   <= ROM_DEPTH;
                     err_q   <= 1'b1;
                     state_q <= ST_DATA;
                  end else begin
                     cnt_q   <= hdr_n_d;
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  byte_idx_q <= byte_idx_q + 1'b1;
                  case (byte_idx_q)
                     2'd0: dat_q[7:0]   <= rx_byte;
                     2'd1: dat_q[15:8]  <= rx_byte;
                     2'd2: dat_q[23:16] <= rx_byte;
                     default: begin
                        wen_q  <= 1'b1;
                        adr_q  <= widx_q[ADDR_W-1:0];
                        wdat_q <= {rx_byte, dat_q};
                     end
                  endcase
               end
               // Index advances the cycle after the strobe; the widened index makes
               // a full-depth count terminate without the address ever wrapping.
               if (wen_q) begin
                  widx_q <= widx_d;
                  if (HDR_W'(widx_d) == cnt_q) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done_q <= 1'b1;
            end
            default: state_q <= ST_HDR0;
         endcase
      end
   end

   assign upg_clk_o   = clock;
   assign upg_wen_o   = wen_q;
   assign upg_adr_o   = adr_q;
   assign upg_dat_o   = wdat_q;
   assign upg_done_o  = done_q;
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomised bench for uart_prog_loader: UART byte driver, stream-level reference model
// that predicts ROM writes / done / err, and a strobe scoreboard.
module tb_uart_prog_loader;
   import uart_prog_loader_pkg::*;

   localparam int CPB   = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst_n;
   logic          upg_rst;
   logic          rx;
   logic          upg_clk;
   logic          wen;
   logic [AW-1:0] adr;
   logic [31:0]   dat;
   logic          done;
   logic          err;
   logic [1:0]    dbg_state;
   logic [1:0]    dbg_rx_state;

   logic [AW+31:0] exp_q[$];
   logic [7:0]     tx_q[$];
   bit             bad_q[$];
   int             n_checks;
   int             n_fail;
   int             wen_count;
   int             exp_cnt;
   bit             exp_done;
   bit             exp_err;
   logic [AW+31:0] last_wr;
   bit             prev_wen;

   uart_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW)
   ) dut (
      .clock          (clk),
      .reset          (rst_n),
      .upg_rst_i      (upg_rst),
      .rx_i           (rx),
      .upg_clk_o      (upg_clk),
      .upg_wen_o      (wen),
      .upg_adr_o      (adr),
      .upg_dat_o      (dat),
      .upg_done_o     (done),
      .err_o          (err),
      .dbg_state_o    (dbg_state),
      .dbg_rx_state_o (dbg_rx_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: got no end of test, required end before time limit");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
      rx = 1'b1;
      if (!stop_ok) repeat (CPB) @(negedge clk);
      repeat ($urandom_range(1, 6)) @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] b, input bit bad);
      tx_q.push_back(b);
      bad_q.push_back(bad);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8], 1'b0);
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) send_byte(tx_q[i], !bad_q[i]);
   endtask

   // Reference model: bad bytes vanish, the first two good bytes are the count,
   // each following group of four good bytes is one word, up to the (saturated) count.
   task automatic build_model();
      logic [7:0]  good[$];
      logic [31:0] w;
      int          n;
      int          nw;
      bit          any_bad;
      any_bad = 1'b0;
      foreach (tx_q[i]) begin
         if (bad_q[i]) any_bad = 1'b1;
         else good.push_back(tx_q[i]);
      end
      n       = int'(good[0]) + 256 * int'(good[1]);
      exp_err = any_bad || (n > DEPTH);
      if (n > DEPTH) n = DEPTH;
      nw = (good.size() - 2) / 4;
      if (nw > n) nw = n;
      exp_done = (nw == n);
      exp_cnt  = nw;
      for (int k = 0; k < nw; k++) begin
         w = {good[2+4*k+3], good[2+4*k+2], good[2+4*k+1], good[2+4*k]};
         exp_q.push_back({AW'(k), w});
         last_wr = {AW'(k), w};
      end
   endtask

   task automatic start_session();
      upg_rst = 1'b1;
      repeat (3) @(negedge clk);
      check("clr.state", dbg_state, ST_HDR0);
      check("clr.done", done, 1'b0);
      check("clr.err", err, 1'b0);
      check("clr.adr", adr, 0);
      upg_rst = 1'b0;
      exp_q.delete();
      tx_q.delete();
      bad_q.delete();
      wen_count = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic finish_session(input string tag);
      repeat (60) @(negedge clk);
      check({tag, ".pending"}, exp_q.size(), 0);
      check({tag, ".wr_count"}, wen_count, exp_cnt);
      check({tag, ".done"}, done, exp_done);
      check({tag, ".err"}, err, exp_err);
      if (exp_cnt > 0) begin
         check({tag, ".adr_hold"}, adr, last_wr[AW+31:32]);
         check({tag, ".dat_hold"}, dat, last_wr[31:0]);
      end
   endtask

   task automatic push_basic_stream();
      push_byte(8'h02, 1'b0);
      push_byte(8'h00, 1'b0);
      push_word(32'h1234_5678);
      push_word(32'hDEAD_BEEF);
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (wen) begin
         wen_count++;
         check("wen_1cyc", prev_wen, 1'b0);
         check("wr_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            last_wr = exp_q.pop_front();
            check("wr_adr", adr, last_wr[AW+31:32]);
            check("wr_dat", dat, last_wr[31:0]);
         end
      end
      prev_wen = wen;
   end

   initial begin
      int n;
      int bad_pos;
      n_checks  = 0;
      n_fail    = 0;
      wen_count = 0;
      prev_wen  = 1'b0;
      rst_n     = 1'b0;
      upg_rst   = 1'b1;
      rx        = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.wen", wen, 1'b0);
      check("rst.adr", adr, 0);
      check("rst.dat", dat, 0);
      check("rst.done", done, 1'b0);
      check("rst.err", err, 1'b0);
      check("rst.state", dbg_state, ST_HDR0);
      check("rst.clk_lo", upg_clk, clk);
      @(posedge clk);
      #1;
      check("rst.clk_hi", upg_clk, clk);
      @(negedge clk);
      rst_n = 1'b1;

      // two-word program
      start_session();
      push_basic_stream();
      build_model();
      send_range(0, tx_q.size());
      finish_session("basic");

      // zero-length program
      start_session();
      push_byte(8'h00, 1'b0);
      push_byte(8'h00, 1'b0);
      build_model();
      send_range(0, 2);
      check("zero.done_fast", done, 1'b1);
      finish_session("zero");

      // count overflow saturates at ROM depth
      start_session();
      push_byte(8'h20, 1'b0);
      push_byte(8'h00, 1'b0);
      for (int k = 0; k < 16; k++) push_word($urandom);
      for (int k = 0; k < 8; k++) push_byte(8'($urandom_range(0, 255)), 1'b0);
      build_model();
      send_range(0, 2);
      check("ovf.err_hdr", err, 1'b1);
      send_range(2, tx_q.size());
      finish_session("ovf");

      // framing error mid-word
      start_session();
      push_byte(8'h02, 1'b0);
      push_byte(8'h00, 1'b0);
      push_byte(8'h11, 1'b0);
      push_byte(8'h22, 1'b0);
      push_byte(8'hAA, 1'b1);
      push_byte(8'h33, 1'b0);
      push_byte(8'h44, 1'b0);
      push_word($urandom);
      build_model();
      send_range(0, tx_q.size());
      finish_session("ferr");

      // short glitch, then a normal one-word program
      start_session();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch.err", err, 1'b0);
      check("glitch.rx_idle", dbg_rx_state, RX_IDLE);
      check("glitch.state", dbg_state, ST_HDR0);
      push_byte(8'h01, 1'b0);
      push_byte(8'h00, 1'b0);
      push_word($urandom);
      build_model();
      send_range(0, tx_q.size());
      finish_session("glitch");

      // reset mid-word and mid-frame, then resend
      start_session();
      push_basic_stream();
      send_range(0, 4);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("abort.wen_count", wen_count, 0);
      check("abort.state", dbg_state, ST_HDR0);
      check("abort.rx_state", dbg_rx_state, RX_IDLE);
      check("abort.dat", dat, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tx_q.delete();
      bad_q.delete();
      push_basic_stream();
      build_model();
      send_range(0, tx_q.size());
      finish_session("resend");

      // upg_rst after done starts fresh sessions from adr 0
      for (int s = 0; s < 3; s++) begin
         start_session();
         n = $urandom_range(1, 4);
         bad_pos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * n - 1) : -1;
         push_byte(8'(n), 1'b0);
         push_byte(8'h00, 1'b0);
         for (int k = 0; k < 4 * n; k++) begin
            if (k == bad_pos) push_byte(8'($urandom_range(0, 255)), 1'b1);
            push_byte(8'($urandom_range(0, 255)), 1'b0);
         end
         build_model();
         send_range(0, tx_q.size());
         finish_session("rand");
      end

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
